// File: rtl/led_ctrl_periph.sv
// led_ctrl_periph
//   Memory-mapped LED controller on the core's data bus. Software selects a
//   static level, free-running blink, or a counted burst of pulses; the
//   half-period (in clocks) is programmable.
//
// Register window (word offsets, bus_addr[1:0] ignored):
//   0x0 CTRL   rw  [0] EN, [2:1] MODE (0 static, 1 blink, 2 burst, 3 static), [3] LEVEL
//   0x4 HALF   rw  half-period in clocks (a write of 0 is stored as 1)
//   0x8 BURST  wo  [15:0] N, launches N pulses when EN=1 and MODE=2 (reads 0)
//   0xC STATUS ro  [0] led_out, [1] busy, [31:16] remaining pulses
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   bus_req    transaction request
//   bus_we     1 = write, 0 = read
//   bus_addr   byte address
//   bus_wdata  write data
//   bus_ack    one-cycle acknowledge
//   bus_rdata  read data, valid with bus_ack, 0 otherwise
//   led_out    registered LED drive
//
// Handshake: a request is accepted on a rising edge where bus_req is high and
// bus_ack is low; bus_ack is high for exactly the following cycle. A request
// seen while bus_ack is high is ignored, so a master holding bus_req is
// accepted every other cycle. Read data reflects register contents in the
// cycle of acceptance.
//
// The FSM state register is named `state` so checkers can bind to it.
module led_ctrl_periph #(
  parameter int unsigned DEF_HALF = 25_000_000,
  parameter int          ADDR_W   = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic              bus_ack,
  output logic [31:0]       bus_rdata,
  output logic              led_out
);

  localparam logic [31:0] HALF_RST = (DEF_HALF == 0) ? 32'd1 : 32'(DEF_HALF);
  localparam int          WIDX_W   = ADDR_W - 2;
  localparam logic [1:0]  M_BLINK  = 2'd1;
  localparam logic [1:0]  M_BURST  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  // Registers
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_level;
  logic [31:0] half_q;

  // One-cycle requests from the bus side to the FSM; they delay FSM reaction
  // by one cycle so registers are visible before the LED responds.
  logic        abort_pend;
  logic        burst_go;
  logic [15:0] burst_n;

  // FSM
  state_t      state;
  logic [31:0] cnt;
  logic [31:0] term;
  logic [15:0] rem;

  // Bus decode
  logic              accept;
  logic [WIDX_W-1:0] widx;
  logic [1:0]        byte_off_unused;
  logic              sel_ctrl, sel_half, sel_burst, sel_status;
  logic [31:0]       rd_mux;
  logic              busy;

  assign accept          = bus_req && !bus_ack;
  assign widx            = bus_addr[ADDR_W-1:2];
  assign byte_off_unused = bus_addr[1:0];
  assign sel_ctrl        = (widx == WIDX_W'(0));
  assign sel_half        = (widx == WIDX_W'(1));
  assign sel_burst       = (widx == WIDX_W'(2));
  assign sel_status      = (widx == WIDX_W'(3));
  assign busy            = (rem != 16'd0);

  always_comb begin
    rd_mux = '0;
    if (sel_ctrl)   rd_mux = {28'd0, ctrl_level, ctrl_mode, ctrl_en};
    if (sel_half)   rd_mux = half_q;
    if (sel_status) rd_mux = {rem, 14'd0, busy, led_out};
  end

  // Bus side: registers, acknowledge, read data
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus_ack    <= 1'b0;
      bus_rdata  <= '0;
      ctrl_en    <= 1'b0;
      ctrl_mode  <= 2'd0;
      ctrl_level <= 1'b0;
      half_q     <= HALF_RST;
      abort_pend <= 1'b0;
      burst_go   <= 1'b0;
      burst_n    <= '0;
    end else begin
      bus_ack    <= accept;
      bus_rdata  <= (accept && !bus_we) ? rd_mux : 32'd0;
      abort_pend <= 1'b0;
      burst_go   <= 1'b0;
      if (accept && bus_we) begin
        if (sel_ctrl) begin
          ctrl_en    <= bus_wdata[0];
          ctrl_mode  <= bus_wdata[2:1];
          ctrl_level <= bus_wdata[3];
          // Only a change of EN or MODE restarts the pattern; LEVEL alone does not.
          abort_pend <= (bus_wdata[0] != ctrl_en) || (bus_wdata[2:1] != ctrl_mode);
        end
        if (sel_half) begin
          half_q <= (bus_wdata == 32'd0) ? 32'd1 : bus_wdata;
        end
        if (sel_burst && ctrl_en && (ctrl_mode == M_BURST) && (bus_wdata[15:0] != 16'd0)) begin
          burst_go <= 1'b1;
          burst_n  <= bus_wdata[15:0];
        end
      end
    end
  end

  // FSM next-state. An abort is folded in by treating the current state as
  // IDLE with cleared counters, so the new mode takes effect in the same cycle
  // and an abort always beats a coincident phase end.
  state_t      cur_state, nxt_state;
  logic [31:0] cur_cnt, nxt_cnt, nxt_term;
  logic [15:0] cur_rem, nxt_rem;
  logic        phase_end, nxt_led;

  always_comb begin
    cur_state = abort_pend ? S_IDLE : state;
    cur_cnt   = abort_pend ? 32'd0 : cnt;
    cur_rem   = abort_pend ? 16'd0 : rem;
    // term is latched at phase entry, so a HALF write only affects later phases
    phase_end = (cur_cnt == term - 32'd1);
    nxt_state = cur_state;
    nxt_cnt   = cur_cnt;
    nxt_term  = term;
    nxt_rem   = cur_rem;
    nxt_led   = 1'b0;
    if (!ctrl_en) begin
      nxt_state = S_IDLE;
      nxt_cnt   = 32'd0;
      nxt_rem   = 16'd0;
    end else if (ctrl_mode == M_BLINK) begin
      if (cur_state == S_IDLE) begin
        nxt_state = S_ON;
        nxt_cnt   = 32'd0;
        nxt_term  = half_q;
      end else if (phase_end) begin
        nxt_state = (cur_state == S_ON) ? S_OFF : S_ON;
        nxt_cnt   = 32'd0;
        nxt_term  = half_q;
      end else begin
        nxt_cnt = cur_cnt + 32'd1;
      end
      nxt_led = (nxt_state == S_ON);
    end else if (ctrl_mode == M_BURST) begin
      if (burst_go) begin
        // Launch or restart, even while a burst is already running
        nxt_state = S_ON;
        nxt_cnt   = 32'd0;
        nxt_term  = half_q;
        nxt_rem   = burst_n;
      end else if (cur_state == S_ON && phase_end) begin
        nxt_state = S_OFF;
        nxt_cnt   = 32'd0;
        nxt_term  = half_q;
      end else if (cur_state == S_OFF && phase_end) begin
        // A pulse completes at the end of its OFF phase
        nxt_cnt = 32'd0;
        nxt_rem = cur_rem - 16'd1;
        if (cur_rem == 16'd1) begin
          nxt_state = S_IDLE;
        end else begin
          nxt_state = S_ON;
          nxt_term  = half_q;
        end
      end else if (cur_state != S_IDLE) begin
        nxt_cnt = cur_cnt + 32'd1;
      end
      nxt_led = (nxt_state == S_ON);
    end else begin
      nxt_state = S_IDLE;
      nxt_cnt   = 32'd0;
      nxt_rem   = 16'd0;
      nxt_led   = ctrl_level;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      term    <= HALF_RST;
      rem     <= '0;
      led_out <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      term    <= nxt_term;
      rem     <= nxt_rem;
      led_out <= nxt_led;
    end
  end

endmodule
